// File: rtl/pipe_ctrl_if.sv
// Pipeline control bundle: hazard/redirect/memory-busy/halt requests flowing
// into the stall sequencer, and per-stage register enables/flushes flowing
// back out to the PC and pipeline registers.
interface pipe_ctrl_if;
    // Requests toward the sequencer
    logic hazard_req;
    logic redirect;
    logic imem_stall;
    logic dmem_stall;
    logic halt_dec;

    // Per-stage register controls from the sequencer
    logic pc_en;
    logic fd_en;
    logic fd_flush;
    logic de_en;
    logic de_flush;
    logic em_en;
    logic mw_en;
    logic mw_flush;

    // Pipeline side: raises requests, consumes enables/flushes
    modport master (
        output hazard_req, redirect, imem_stall, dmem_stall, halt_dec,
        input  pc_en, fd_en, fd_flush, de_en, de_flush, em_en, mw_en, mw_flush
    );

    // Sequencer side
    modport slave (
        input  hazard_req, redirect, imem_stall, dmem_stall, halt_dec,
        output pc_en, fd_en, fd_flush, de_en, de_flush, em_en, mw_en, mw_flush
    );
endinterface

// File: rtl/pipe_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline.
// Enables and flushes are decoded combinationally from the current state and
// the request inputs so they act in the same cycle; the halt flag, timeout
// flag and stall-cycle counter are registered. HALTED and ERR are absorbing
// states left only through the asynchronous active-low reset.
module pipe_ctrl #(
    parameter int CNT_W       = 16,
    parameter int MEM_TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             rst,
    pipe_ctrl_if.slave       bus,
    output logic             halted,
    output logic             timeout_err,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef enum logic [1:0] {
        ST_RUN    = 2'b00,
        ST_DWAIT  = 2'b01,
        ST_HALTED = 2'b10,
        ST_ERR    = 2'b11
    } state_e;

    // The wait counter already holds 1 after the RUN entry cycle, so the
    // timeout fires on the DWAIT cycle that finds MEM_TIMEOUT-1 stored.
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(MEM_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX      = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE      = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ZERO     = {CNT_W{1'b0}};

    state_e           state_q,     state_d;
    logic [CNT_W-1:0] wait_cnt_q,  wait_cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic             halted_q,    halted_d;
    logic             err_q,       err_d;

    // Raw (pre-reset-gating) stage controls
    logic pc_en_s;
    logic fd_en_s;
    logic fd_flush_s;
    logic de_en_s;
    logic de_flush_s;
    logic em_en_s;
    logic mw_en_s;
    logic mw_flush_s;

    // Next-state, wait-counter and same-cycle enable/flush decode
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        pc_en_s    = 1'b0;
        fd_en_s    = 1'b0;
        fd_flush_s = 1'b0;
        de_en_s    = 1'b0;
        de_flush_s = 1'b0;
        em_en_s    = 1'b0;
        mw_en_s    = 1'b0;
        mw_flush_s = 1'b0;
        case (state_q)
            ST_RUN, ST_DWAIT: begin
                if (bus.dmem_stall) begin
                    // Freeze everything up to MEM; WB takes a bubble.
                    // Younger requests are held in frozen stages and re-present.
                    mw_en_s    = 1'b1;
                    mw_flush_s = 1'b1;
                    if (state_q == ST_DWAIT) begin
                        if (wait_cnt_q >= TIMEOUT_LAST) begin
                            state_d    = ST_ERR;
                            wait_cnt_d = CNT_ZERO;
                        end else begin
                            state_d    = ST_DWAIT;
                            wait_cnt_d = wait_cnt_q + CNT_ONE;
                        end
                    end else begin
                        state_d    = ST_DWAIT;
                        wait_cnt_d = CNT_ONE;
                    end
                end else begin
                    wait_cnt_d = CNT_ZERO;
                    if (bus.halt_dec) begin
                        state_d = ST_HALTED;
                    end else begin
                        state_d = ST_RUN;
                    end
                    if (bus.redirect) begin
                        // Squash the two younger instructions behind the branch
                        pc_en_s    = 1'b1;
                        fd_en_s    = 1'b1;
                        fd_flush_s = 1'b1;
                        de_en_s    = 1'b1;
                        de_flush_s = 1'b1;
                        em_en_s    = 1'b1;
                        mw_en_s    = 1'b1;
                    end else if (bus.hazard_req) begin
                        // Hold PC and IF/ID; bubble into ID/EX. Holding IF/ID
                        // also covers a concurrent imem stall (no IF flush).
                        de_en_s    = 1'b1;
                        de_flush_s = 1'b1;
                        em_en_s    = 1'b1;
                        mw_en_s    = 1'b1;
                    end else if (bus.imem_stall) begin
                        // No new fetch: keep PC, feed a NOP into IF/ID
                        fd_en_s    = 1'b1;
                        fd_flush_s = 1'b1;
                        de_en_s    = 1'b1;
                        em_en_s    = 1'b1;
                        mw_en_s    = 1'b1;
                    end else begin
                        pc_en_s = 1'b1;
                        fd_en_s = 1'b1;
                        de_en_s = 1'b1;
                        em_en_s = 1'b1;
                        mw_en_s = 1'b1;
                    end
                end
            end
            ST_HALTED: begin
                state_d    = ST_HALTED;
                wait_cnt_d = CNT_ZERO;
            end
            ST_ERR: begin
                state_d    = ST_ERR;
                wait_cnt_d = CNT_ZERO;
            end
            default: begin
                state_d    = ST_ERR;
                wait_cnt_d = CNT_ZERO;
            end
        endcase
    end

    // Sticky status flags and saturating stall-cycle counter next values
    always_comb begin
        halted_d    = halted_q;
        err_d       = err_q;
        stall_cnt_d = stall_cnt_q;
        if (state_d == ST_HALTED) begin
            halted_d = 1'b1;
        end else begin
            halted_d = halted_q;
        end
        if (state_d == ST_ERR) begin
            err_d = 1'b1;
        end else begin
            err_d = err_q;
        end
        if (((state_q == ST_RUN) || (state_q == ST_DWAIT)) && !pc_en_s &&
            (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + CNT_ONE;
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
    end

    // State, wait counter, stall counter and sticky flag registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_RUN;
            wait_cnt_q  <= CNT_ZERO;
            stall_cnt_q <= CNT_ZERO;
            halted_q    <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            halted_q    <= halted_d;
            err_q       <= err_d;
        end
    end

    // Force every stage control low while reset is asserted
    always_comb begin
        if (!rst) begin
            bus.pc_en    = 1'b0;
            bus.fd_en    = 1'b0;
            bus.fd_flush = 1'b0;
            bus.de_en    = 1'b0;
            bus.de_flush = 1'b0;
            bus.em_en    = 1'b0;
            bus.mw_en    = 1'b0;
            bus.mw_flush = 1'b0;
        end else begin
            bus.pc_en    = pc_en_s;
            bus.fd_en    = fd_en_s;
            bus.fd_flush = fd_flush_s;
            bus.de_en    = de_en_s;
            bus.de_flush = de_flush_s;
            bus.em_en    = em_en_s;
            bus.mw_en    = mw_en_s;
            bus.mw_flush = mw_flush_s;
        end
    end

    assign halted      = halted_q;
    assign timeout_err = err_q;
    assign stall_cnt   = stall_cnt_q;

endmodule
